// File: rtl/calc_entry_seq_if.sv
`default_nettype none
// ============================================================================
// Module  : calc_entry_seq_if
// Brief   : Key stream, calculator-core bus and result signals of the sequencer
// Revision: 1.0
// ============================================================================
interface calc_entry_seq_if;
    logic       key_valid;
    logic       key_ready;
    logic [1:0] key_type;
    logic [3:0] key_val;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] oper;
    logic [7:0] result_in;
    logic [7:0] result_out;
    logic       result_valid;
    logic       err;
    logic       busy;

    modport master (
        output key_valid, key_type, key_val, result_in,
        input  key_ready, a, b, oper, result_out, result_valid, err, busy
    );

    modport slave (
        input  key_valid, key_type, key_val, result_in,
        output key_ready, a, b, oper, result_out, result_valid, err, busy
    );
endinterface
`default_nettype wire

// File: rtl/calc_entry_seq.sv
`default_nettype none
// ============================================================================
// Module  : calc_entry_seq
// Brief   : Key-entry sequencer feeding a 4-bit calculator core, with chaining
// Revision: 1.0
// ============================================================================
module calc_entry_seq #(
    parameter int SETTLE_CYCLES = 1
) (
    input wire              clk,
    input wire              rst_n,
    calc_entry_seq_if.slave bus
);

    localparam logic [2:0] S_A  = 3'd0;
    localparam logic [2:0] S_OP = 3'd1;
    localparam logic [2:0] S_B  = 3'd2;
    localparam logic [2:0] EXEC = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    localparam int            CW         = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] c_CNT_INIT = CW'(SETTLE_CYCLES - 1);

    localparam logic [1:0] c_KEY_DIGIT = 2'b00;
    localparam logic [1:0] c_KEY_OP    = 2'b01;
    localparam logic [1:0] c_KEY_EQ    = 2'b10;
    localparam logic [1:0] c_KEY_CLR   = 2'b11;

    localparam logic [2:0] c_OP_DIV = 3'b011;
    localparam logic [2:0] c_OP_MOD = 3'b100;
    localparam logic [2:0] c_OP_NOT = 3'b101;

    logic [2:0]    r_state;
    logic [3:0]    r_a;
    logic [3:0]    r_b;
    logic [2:0]    r_oper;
    logic [7:0]    r_result;
    logic          r_rvalid;
    logic          r_err;
    logic [CW-1:0] r_cnt;

    logic       w_ready;
    logic       w_take;
    logic       w_digit;
    logic       w_op;
    logic       w_eq;
    logic       w_clr;
    logic [2:0] w_opc;
    logic       w_opc_not;
    logic       w_div_zero;

    assign w_ready    = (r_state != EXEC);
    assign w_take     = bus.key_valid && w_ready;
    assign w_opc      = bus.key_val[2:0];
    assign w_opc_not  = (w_opc == c_OP_NOT);
    assign w_digit    = (bus.key_type == c_KEY_DIGIT);
    // Opcodes above NOT are swallowed like any unlisted key.
    assign w_op       = (bus.key_type == c_KEY_OP) && (w_opc <= c_OP_NOT);
    assign w_eq       = (bus.key_type == c_KEY_EQ);
    assign w_clr      = (bus.key_type == c_KEY_CLR);
    assign w_div_zero = ((r_oper == c_OP_DIV) || (r_oper == c_OP_MOD)) && (r_b == 4'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_A;
            r_a      <= '0;
            r_b      <= '0;
            r_oper   <= '0;
            r_result <= '0;
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_rvalid <= 1'b0;
            if (r_state == EXEC) begin
                if (r_cnt == '0) begin
                    r_result <= bus.result_in;
                    r_rvalid <= 1'b1;
                    r_state  <= DONE;
                end else begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end else if (w_take) begin
                if (w_clr) begin
                    r_a      <= '0;
                    r_b      <= '0;
                    r_oper   <= '0;
                    r_result <= '0;
                    r_err    <= 1'b0;
                    r_state  <= S_A;
                end else begin
                    case (r_state)
                        S_A: begin
                            if (w_digit) begin
                                r_a <= bus.key_val;
                            end else if (w_op) begin
                                r_oper <= w_opc;
                                if (w_opc_not) begin
                                    r_b     <= '0;
                                    r_cnt   <= c_CNT_INIT;
                                    r_state <= EXEC;
                                end else begin
                                    r_state <= S_OP;
                                end
                            end
                        end
                        S_OP: begin
                            if (w_digit) begin
                                r_b     <= bus.key_val;
                                r_state <= S_B;
                            end else if (w_op) begin
                                r_oper <= w_opc;
                                if (w_opc_not) begin
                                    r_b     <= '0;
                                    r_cnt   <= c_CNT_INIT;
                                    r_state <= EXEC;
                                end
                            end
                        end
                        S_B: begin
                            if (w_digit) begin
                                r_b <= bus.key_val;
                            end else if (w_eq) begin
                                // Division by zero never reaches the core.
                                if (w_div_zero) begin
                                    r_err    <= 1'b1;
                                    r_result <= '0;
                                    r_rvalid <= 1'b1;
                                    r_state  <= DONE;
                                end else begin
                                    r_cnt   <= c_CNT_INIT;
                                    r_state <= EXEC;
                                end
                            end
                        end
                        DONE: begin
                            if (w_digit) begin
                                r_a     <= bus.key_val;
                                r_b     <= '0;
                                r_oper  <= '0;
                                r_err   <= 1'b0;
                                r_state <= S_A;
                            end else if (w_op) begin
                                // Chaining keeps only the low nibble of the previous result.
                                r_a    <= r_result[3:0];
                                r_oper <= w_opc;
                                r_err  <= 1'b0;
                                if (w_opc_not) begin
                                    r_b     <= '0;
                                    r_cnt   <= c_CNT_INIT;
                                    r_state <= EXEC;
                                end else begin
                                    r_state <= S_OP;
                                end
                            end
                        end
                        default: r_state <= S_A;
                    endcase
                end
            end
        end
    end

    assign bus.key_ready    = w_ready;
    assign bus.busy         = (r_state == EXEC);
    assign bus.a            = r_a;
    assign bus.b            = r_b;
    assign bus.oper         = r_oper;
    assign bus.result_out   = r_result;
    assign bus.result_valid = r_rvalid;
    assign bus.err          = r_err;

endmodule
`default_nettype wire

// File: tb/tb_calc_entry_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_calc_entry_seq
// Brief   : Directed scoreboard bench for calc_entry_seq (SETTLE 1 and 4)
// Revision: 1.0
// ============================================================================
module tb_calc_entry_seq;

    localparam logic [1:0] D  = 2'b00;
    localparam logic [1:0] OP = 2'b01;
    localparam logic [1:0] EQ = 2'b10;
    localparam logic [1:0] CL = 2'b11;

    typedef struct packed {
        logic [7:0] res;
        logic       err;
    } exp_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       kv    = 1'b0;
    logic       sel   = 1'b0;
    logic [1:0] kt    = 2'b00;
    logic [3:0] kval  = 4'd0;
    logic       prev_rv1 = 1'b0;
    logic       prev_rv4 = 1'b0;

    int   checks = 0;
    int   errors = 0;
    exp_t q1[$];
    exp_t q4[$];

    always #5 clk = ~clk;

    calc_entry_seq_if if1 ();
    calc_entry_seq_if if4 ();

    function automatic logic [7:0] core(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        logic [7:0] ea;
        logic [7:0] eb;
        ea = {4'd0, a};
        eb = {4'd0, b};
        case (op)
            3'd0:    return ea + eb;
            3'd1:    return ea - eb;
            3'd2:    return ea * eb;
            3'd3:    return (b == 4'd0) ? 8'd0 : ea / eb;
            3'd4:    return (b == 4'd0) ? 8'd0 : ea % eb;
            3'd5:    return ~ea;
            default: return 8'd0;
        endcase
    endfunction

    assign if1.key_valid = kv & ~sel;
    assign if1.key_type  = kt;
    assign if1.key_val   = kval;
    assign if1.result_in = core(if1.a, if1.b, if1.oper);
    assign if4.key_valid = kv & sel;
    assign if4.key_type  = kt;
    assign if4.key_val   = kval;
    assign if4.result_in = core(if4.a, if4.b, if4.oper);

    calc_entry_seq #(.SETTLE_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    calc_entry_seq #(.SETTLE_CYCLES(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitors: every result_valid pulse must match the next queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (if1.result_valid === 1'b1) begin
            chk("rv1_not_back_to_back", {31'd0, prev_rv1}, 32'd0);
            if (q1.size() == 0) begin
                chk("rv1_unexpected", 32'd1, 32'd0);
            end else begin
                e = q1.pop_front();
                chk("result_out1", {24'd0, if1.result_out}, {24'd0, e.res});
                chk("err1", {31'd0, if1.err}, {31'd0, e.err});
            end
        end
        if (if4.result_valid === 1'b1) begin
            chk("rv4_not_back_to_back", {31'd0, prev_rv4}, 32'd0);
            if (q4.size() == 0) begin
                chk("rv4_unexpected", 32'd1, 32'd0);
            end else begin
                e = q4.pop_front();
                chk("result_out4", {24'd0, if4.result_out}, {24'd0, e.res});
                chk("err4", {31'd0, if4.err}, {31'd0, e.err});
            end
        end
        prev_rv1 <= (if1.result_valid === 1'b1);
        prev_rv4 <= (if4.result_valid === 1'b1);
    end

    task automatic send(input logic [1:0] t, input logic [3:0] v);
        int n;
        @(negedge clk);
        kv   = 1'b1;
        kt   = t;
        kval = v;
        n    = 0;
        while (((sel ? if4.key_ready : if1.key_ready) !== 1'b1) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if ((sel ? if4.key_ready : if1.key_ready) !== 1'b1)
            chk("key_accept_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        kv = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q1.size() != 0 || q4.size() != 0) && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("result_timeout", q1.size() + q4.size(), 32'd0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_a",      {28'd0, if1.a}, 32'd0);
        chk("rst_b",      {28'd0, if1.b}, 32'd0);
        chk("rst_oper",   {29'd0, if1.oper}, 32'd0);
        chk("rst_result", {24'd0, if1.result_out}, 32'd0);
        chk("rst_rvalid", {31'd0, if1.result_valid}, 32'd0);
        chk("rst_err",    {31'd0, if1.err}, 32'd0);
        chk("rst_busy",   {31'd0, if1.busy}, 32'd0);
        chk("rst_ready",  {31'd0, if1.key_ready}, 32'd1);
        rst_n = 1'b1;

        // 7 + 5, single settle cycle
        send(D, 4'd7); send(OP, 4'd0); send(D, 4'd5);
        chk("t1_a", {28'd0, if1.a}, 32'd7);
        chk("t1_b", {28'd0, if1.b}, 32'd5);
        q1.push_back('{res: 8'h0C, err: 1'b0});
        send(EQ, 4'd0);
        @(negedge clk);
        chk("t1_busy_exec",  {31'd0, if1.busy}, 32'd1);
        chk("t1_ready_exec", {31'd0, if1.key_ready}, 32'd0);
        @(negedge clk);
        chk("t1_busy_done",  {31'd0, if1.busy}, 32'd0);
        drain();

        // Chain 0x0C * 2
        send(OP, 4'd2);
        chk("t4_chain_a", {28'd0, if1.a}, 32'hC);
        chk("t4_oper",    {29'd0, if1.oper}, 32'd2);
        send(D, 4'd2);
        q1.push_back('{res: 8'h18, err: 1'b0});
        send(EQ, 4'd0);
        drain();

        // Chain truncates 0x18 to 8; 8 + 1
        send(OP, 4'd0);
        chk("trunc_a", {28'd0, if1.a}, 32'd8);
        send(D, 4'd1);
        q1.push_back('{res: 8'h09, err: 1'b0});
        send(EQ, 4'd0);
        drain();

        // New digit after result; 2 - 5 wraps
        send(D, 4'd2);
        chk("sub_b_cleared",    {28'd0, if1.b}, 32'd0);
        chk("sub_oper_cleared", {29'd0, if1.oper}, 32'd0);
        send(OP, 4'd1); send(D, 4'd5);
        q1.push_back('{res: 8'hFD, err: 1'b0});
        send(EQ, 4'd0);
        drain();

        // Divide by zero skips EXEC
        send(D, 4'd9); send(OP, 4'd3); send(D, 4'd0);
        q1.push_back('{res: 8'h00, err: 1'b1});
        send(EQ, 4'd0);
        chk("t2_no_busy",  {31'd0, if1.busy}, 32'd0);
        chk("t2_ready",    {31'd0, if1.key_ready}, 32'd1);
        drain();
        send(EQ, 4'd0);
        chk("t2_err_held", {31'd0, if1.err}, 32'd1);

        // NOT goes straight to EXEC
        send(D, 4'd3);
        chk("t3_err_clr", {31'd0, if1.err}, 32'd0);
        q1.push_back('{res: 8'hFC, err: 1'b0});
        send(OP, 4'd5);
        chk("t3_b_zero", {28'd0, if1.b}, 32'd0);
        chk("t3_busy",   {31'd0, if1.busy}, 32'd1);
        drain();
        send(D, 4'd2);
        chk("t3_a",    {28'd0, if1.a}, 32'd2);
        chk("t3_oper", {29'd0, if1.oper}, 32'd0);
        chk("t3_err",  {31'd0, if1.err}, 32'd0);

        // Modulo by zero
        send(OP, 4'd4); send(D, 4'd0);
        q1.push_back('{res: 8'h00, err: 1'b1});
        send(EQ, 4'd0);
        drain();

        // Key held through EXEC is not consumed until DONE
        send(D, 4'd4); send(OP, 4'd0); send(D, 4'd4);
        q1.push_back('{res: 8'h08, err: 1'b0});
        send(EQ, 4'd0);
        kv = 1'b1; kt = D; kval = 4'd1;
        @(negedge clk);
        chk("t5_ready_low", {31'd0, if1.key_ready}, 32'd0);
        @(posedge clk); #1;
        chk("t5_not_taken", {28'd0, if1.a}, 32'd4);
        @(posedge clk); #1;
        kv = 1'b0;
        chk("t5_taken_a", {28'd0, if1.a}, 32'd1);
        chk("t5_taken_b", {28'd0, if1.b}, 32'd0);
        send(OP, 4'd6);
        chk("t5_bad_op", {29'd0, if1.oper}, 32'd0);
        send(D, 4'd3);
        chk("t5_still_sa_a", {28'd0, if1.a}, 32'd3);
        chk("t5_still_sa_b", {28'd0, if1.b}, 32'd0);
        send(OP, 4'd2); send(D, 4'd5); send(CL, 4'd0);
        chk("clr_a",      {28'd0, if1.a}, 32'd0);
        chk("clr_b",      {28'd0, if1.b}, 32'd0);
        chk("clr_oper",   {29'd0, if1.oper}, 32'd0);
        chk("clr_result", {24'd0, if1.result_out}, 32'd0);
        send(D, 4'd6);
        chk("clr_to_sa", {28'd0, if1.a}, 32'd6);
        chk("clr_b_kept", {28'd0, if1.b}, 32'd0);

        // SETTLE=4: exact EXEC length
        sel = 1'b1;
        send(D, 4'd6); send(OP, 4'd0); send(D, 4'd3);
        q4.push_back('{res: 8'h09, err: 1'b0});
        send(EQ, 4'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("s4_busy", {31'd0, if4.busy}, 32'd1);
        end
        @(negedge clk);
        chk("s4_busy_end", {31'd0, if4.busy}, 32'd0);
        drain();

        // Reset mid-EXEC drops the capture
        send(D, 4'd2); send(OP, 4'd2); send(D, 4'd3); send(EQ, 4'd0);
        @(negedge clk);
        chk("t6_in_exec", {31'd0, if4.busy}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t6_a",      {28'd0, if4.a}, 32'd0);
        chk("t6_b",      {28'd0, if4.b}, 32'd0);
        chk("t6_oper",   {29'd0, if4.oper}, 32'd0);
        chk("t6_result", {24'd0, if4.result_out}, 32'd0);
        chk("t6_busy",   {31'd0, if4.busy}, 32'd0);
        chk("t6_ready",  {31'd0, if4.key_ready}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("t6_result_after", {24'd0, if4.result_out}, 32'd0);
        chk("queues_empty", q1.size() + q4.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
